// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity types and line levels.
// Used by both the TX and RX paths.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // xr is the XOR-reduction of the data word
    function automatic logic par_bit(
        input logic xr,
        input logic typ
    );
        return xr ^ (typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register and bit counter for the UART transmitter.
// ser_bit is always the next data bit to put on the line.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= din;
            cnt   <= '0;
        end else begin
            if (shift) shreg <= shreg >> 1;
            if (step)  cnt   <= cnt + CW'(1);
        end
    end

    assign ser_bit  = shreg[0];
    assign ser_done = (cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, one stop.
// One clock per bit; TX_OUT and busy are registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       tx_nxt;
    logic       accept;
    logic       shift;
    logic       step;
    logic       ser_bit;
    logic       ser_done;
    logic       par_en_q;
    logic       par_q;

    assign accept = (state == IDLE) && Data_Valid;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .shift    (shift),
        .step     (step),
        .din      (P_DATA),
        .ser_bit  (ser_bit),
        .ser_done (ser_done)
    );

    // Outputs are computed from the next state so they stay registered
    always_comb begin
        state_nxt = state;
        tx_nxt    = IDLE_LVL;
        shift     = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (Data_Valid) begin
                    state_nxt = START;
                    tx_nxt    = START_LVL;
                end
            end
            START: begin
                state_nxt = DATA;
                tx_nxt    = ser_bit;
                shift     = 1'b1;
            end
            DATA: begin
                if (ser_done) begin
                    if (par_en_q) begin
                        state_nxt = PARITY;
                        tx_nxt    = par_q;
                    end else begin
                        state_nxt = STOP;
                        tx_nxt    = STOP_LVL;
                    end
                end else begin
                    tx_nxt = ser_bit;
                    shift  = 1'b1;
                    step   = 1'b1;
                end
            end
            PARITY: begin
                state_nxt = STOP;
                tx_nxt    = STOP_LVL;
            end
            STOP: begin
                state_nxt = IDLE;
                tx_nxt    = IDLE_LVL;
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = IDLE_LVL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            TX_OUT <= IDLE_LVL;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            TX_OUT <= tx_nxt;
            busy   <= (state_nxt != IDLE);
        end
    end

    // Parity is fixed from the word captured at acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
        end else if (accept) begin
            par_en_q <= PAR_EN;
            par_q    <= par_bit(^P_DATA, PAR_TYP);
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomised checks for uart_tx.
// Inputs change and outputs are sampled 1 time unit after posedge.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx #(
        .DATA_WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // seq holds the line levels in time order, first bit at seq[n-1].
    // At cycle inj a competing request with inverted settings is raised.
    task automatic run_frame(
        input string       tag,
        input logic [7:0]  d,
        input logic        pen,
        input logic        typ,
        input logic [15:0] seq,
        input int          n,
        input int          inj
    );
        Data_Valid = 1'b1;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = typ;
        tick();
        Data_Valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s bit%0d", tag, i), TX_OUT, seq[n-1-i]);
            check($sformatf("%s busy%0d", tag, i), busy, 1);
            if (i == inj) begin
                Data_Valid = 1'b1;
                P_DATA     = ~d;
                PAR_TYP    = ~typ;
            end else begin
                Data_Valid = 1'b0;
            end
            tick();
        end
        check({tag, " idle tx"}, TX_OUT, 1);
        check({tag, " idle busy"}, busy, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] rx;
        logic       pen;
        logic       typ;
        logic       rxp;
        int         w;

        reset      = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #3 reset   = 1'b0;
        #1;
        check("reset tx", TX_OUT, 1);
        check("reset busy", busy, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post reset tx", TX_OUT, 1);
        check("post reset busy", busy, 0);

        run_frame("a5 even", 8'hA5, 1'b1, 1'b0,
                  16'b01010010101, 11, -1);
        run_frame("01 odd", 8'h01, 1'b1, 1'b1,
                  16'b01000000001, 11, -1);
        run_frame("01 even", 8'h01, 1'b1, 1'b0,
                  16'b01000000011, 11, -1);
        run_frame("ff nopar", 8'hFF, 1'b0, 1'b1,
                  16'b0111111111, 10, -1);

        run_frame("3c midchg", 8'h3C, 1'b1, 1'b0,
                  16'b00011110001, 11, 4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no c3 tx", TX_OUT, 1);
            check("no c3 busy", busy, 0);
        end

        Data_Valid = 1'b1;
        P_DATA     = 8'h0F;
        PAR_EN     = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 10; i++) begin
                check("hold bit", TX_OUT, (i >= 1 && i <= 4) || i == 9);
                check("hold busy", busy, 1);
                tick();
            end
            check("hold gap tx", TX_OUT, 1);
            check("hold gap busy", busy, 0);
            if (k == 2) Data_Valid = 1'b0;
            tick();
        end
        check("hold end tx", TX_OUT, 1);
        check("hold end busy", busy, 0);

        Data_Valid = 1'b1;
        P_DATA     = 8'h55;
        PAR_EN     = 1'b0;
        tick();
        Data_Valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre rst busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("async rst tx", TX_OUT, 1);
        check("async rst busy", busy, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rel rst tx", TX_OUT, 1);
        run_frame("55 after rst", 8'h55, 1'b0, 1'b0,
                  16'b0101010101, 10, -1);

        for (int f = 0; f < 1000; f++) begin
            d   = 8'($urandom);
            pen = 1'($urandom_range(0, 1));
            typ = 1'($urandom_range(0, 1));
            w   = $urandom_range(0, 2);
            for (int g = 0; g < w; g++) tick();
            Data_Valid = 1'b1;
            P_DATA     = d;
            PAR_EN     = pen;
            PAR_TYP    = typ;
            tick();
            Data_Valid = 1'b0;
            P_DATA     = 8'($urandom);
            PAR_TYP    = 1'($urandom_range(0, 1));
            w = 0;
            while (TX_OUT !== 1'b0 && w < 4) begin
                tick();
                w++;
            end
            check("rx start", TX_OUT, 0);
            tick();
            for (int b = 0; b < 8; b++) begin
                rx[b] = TX_OUT;
                tick();
            end
            if (pen) begin
                rxp = TX_OUT;
                check("rx parity", rxp, (^d) ^ typ);
                tick();
            end
            check("rx stop", TX_OUT, 1);
            check("rx byte", rx, d);
            tick();
            check("rx idle busy", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
